// File: rtl/shift_unit.sv
// shift_unit: multi-cycle shift/rotate unit for the ALU datapath.
//
// state  | meaning
// -------+------------------------------------------------------------
// IDLE   | waiting for start; result/carry/illegal hold the last answer
// SHIFT  | moving up to STEP bits per cycle until remaining reaches 0
// DONE   | done pulse for exactly one cycle, then back to IDLE
//
// Ports:
//   Clock    - rising-edge clock
//   Clear    - asynchronous active-high reset
//   start    - request, only sampled in IDLE
//   op       - 000 SHR, 001 SHRA, 010 SHL, 011 ROR, 100 ROL, 101-111 illegal
//   operand  - value to shift, captured with start
//   amount   - shift count 0..WIDTH-1, captured with start
//   busy     - state is not IDLE
//   done     - one-cycle completion pulse
//   result   - accumulator contents
//   carry    - last bit shifted or rotated out
//   zero     - result == 0
//   illegal  - captured op was 101-111
module shift_unit #(
  parameter int WIDTH = 32,
  parameter int STEP  = 1,
  parameter int AW    = $clog2(WIDTH)
) (
  input  logic             Clock,
  input  logic             Clear,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] operand,
  input  logic [AW-1:0]    amount,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             carry,
  output logic             zero,
  output logic             illegal
);

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;

  localparam logic [2:0]  OP_SHR  = 3'd0;
  localparam logic [2:0]  OP_SHRA = 3'd1;
  localparam logic [2:0]  OP_SHL  = 3'd2;
  localparam logic [2:0]  OP_ROR  = 3'd3;
  localparam logic [2:0]  OP_ROL  = 3'd4;
  localparam logic [AW:0] STEP_W  = (AW+1)'(STEP);
  localparam logic [AW:0] WIDTH_W = (AW+1)'(WIDTH);
  localparam logic [AW:0] ONE_W   = (AW+1)'(1);

  state_t           state;
  logic [WIDTH-1:0] acc;
  logic [AW-1:0]    rem;
  logic [2:0]       op_q;
  logic             fill;

  logic [AW-1:0]    k;
  logic [AW:0]      k_ext;
  logic [AW:0]      k_inv;
  logic [WIDTH-1:0] ones;
  logic [WIDTH-1:0] shr_val;
  logic [WIDTH-1:0] shl_val;
  logic [WIDTH-1:0] out_r;
  logic [WIDTH-1:0] out_l;
  logic [WIDTH-1:0] next_acc;
  logic             next_carry;

  // k = min(STEP, remaining). The compare is done one bit wider so that
  // STEP == WIDTH still fits; in that case rem is always the smaller one.
  always_comb begin
    k          = ({1'b0, rem} > STEP_W) ? STEP_W[AW-1:0] : rem;
    k_ext      = {1'b0, k};
    k_inv      = WIDTH_W - k_ext;
    ones       = '1;
    shr_val    = acc >> k;
    shl_val    = acc << k;
    // Bit moved out: acc[k-1] for rightward moves, acc[WIDTH-k] for leftward.
    out_r      = acc >> (k_ext - ONE_W);
    out_l      = acc >> k_inv;
    next_acc   = acc;
    next_carry = carry;
    case (op_q)
      OP_SHR: begin
        next_acc   = shr_val;
        next_carry = out_r[0];
      end
      OP_SHRA: begin
        next_acc   = shr_val | (fill ? ~(ones >> k) : '0);
        next_carry = out_r[0];
      end
      OP_SHL: begin
        next_acc   = shl_val;
        next_carry = out_l[0];
      end
      OP_ROR: begin
        next_acc   = shr_val | (acc << k_inv);
        next_carry = out_r[0];
      end
      OP_ROL: begin
        next_acc   = shl_val | (acc >> k_inv);
        next_carry = out_l[0];
      end
      default: begin
        next_acc   = acc;
        next_carry = carry;
      end
    endcase
  end

  always_ff @(posedge Clock or posedge Clear) begin
    if (Clear) begin
      state   <= S_IDLE;
      acc     <= '0;
      rem     <= '0;
      op_q    <= '0;
      fill    <= 1'b0;
      carry   <= 1'b0;
      illegal <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            acc     <= operand;
            rem     <= amount;
            op_q    <= op;
            fill    <= operand[WIDTH-1];
            carry   <= 1'b0;
            illegal <= (op > OP_ROL);
            state   <= ((amount != '0) && (op <= OP_ROL)) ? S_SHIFT : S_DONE;
          end
        end
        S_SHIFT: begin
          acc   <= next_acc;
          carry <= next_carry;
          rem   <= rem - k;
          if (rem == k) state <= S_DONE;
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  assign result = acc;
  assign busy   = (state != S_IDLE);
  assign done   = (state == S_DONE);
  assign zero   = (acc == '0);

endmodule
